sys_ctrl: RTL
=============

Name: sys_ctrl

Overview:
Command controller and initiator for the register file and ALU. It parses command frames from the UART receiver (parallel bytes), issues register-file write/read strobes and ALU operations, and returns results to the UART transmitter. It sits between UART_RX/UART_TX and REG_FILE/ALU in the reference clock domain.

Parameters:
WIDTH, 8, data/byte width
ADDR_WIDTH, 4, register-file address width
ALU_OUT_WIDTH, 16, ALU result width (= 2*WIDTH)

Ports:
CLK  in  1  system (reference) clock
RST  in  1  asynchronous reset, active low
RX_P_DATA  in  WIDTH  received byte
RX_D_VALID  in  1  one-cycle pulse, RX_P_DATA valid
WrEn  out  1  register-file write strobe
RdEn  out  1  register-file read strobe
Address  out  ADDR_WIDTH  register-file address
WrData  out  WIDTH  register-file write data
RdData  in  WIDTH  register-file read data
RdData_Valid  in  1  RdData valid
ALU_EN  out  1  ALU operation strobe
ALU_FUN  out  4  ALU function code
CLK_GATE_EN  out  1  ALU clock-gate enable
ALU_OUT  in  ALU_OUT_WIDTH  ALU result
ALU_OUT_VALID  in  1  ALU_OUT valid
TX_P_DATA  out  WIDTH  byte to transmit
TX_D_VALID  out  1  one-cycle pulse, TX_P_DATA valid
TX_BUSY  in  1  transmitter busy

Behaviour:
- Decided: one clock CLK; reset RST is asynchronous, active-low.
- All outputs are registered. On reset every output is 0 and the state is IDLE.
- Commands (first byte): 0xAA = RF write (ADDR, DATA); 0xBB = RF read (ADDR); 0xCC = ALU with operands (A, B, FUN); 0xDD = ALU without operands (FUN). Any other first byte is ignored; the FSM stays in IDLE.
- ADDR bytes use bits [ADDR_WIDTH-1:0]; upper bits are ignored. FUN bytes use bits [3:0].
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_B0, TX_B1.
- Bytes advance the FSM only on cycles with RX_D_VALID=1. There is no frame timeout.
- WR_DATA + byte: next cycle WrEn=1 for exactly 1 cycle, with Address=latched ADDR and WrData=byte. The FSM then returns to IDLE.
- RD_ADDR + byte: next cycle RdEn=1 for exactly 1 cycle with Address=byte. The FSM then enters RD_WAIT.
- RD_WAIT: on RdData_Valid=1, capture RdData, then go to TX_B0 with a single-byte response.
- ALU_A + byte: WrEn pulse, Address=0, WrData=A.
- ALU_B + byte: WrEn pulse, Address=1, WrData=B.
- ALU_FUN + byte: next cycle ALU_EN=1 for 1 cycle, ALU_FUN=FUN (held until the next FUN). CLK_GATE_EN=1 from that cycle until ALU_OUT_VALID is sampled high, inclusive. The FSM then enters ALU_WAIT.
- ALU_WAIT: on ALU_OUT_VALID, capture ALU_OUT, then go to TX_B0 with a two-byte response, low byte first.
- TX handshake: TX_D_VALID pulses 1 cycle only in a cycle where TX_BUSY=0 was sampled, with TX_P_DATA stable from that cycle until the next pulse.
- After each pulse the controller waits to see TX_BUSY=1 and then TX_BUSY=0 before the next byte or the return to IDLE.
- TX_B1 sends the high byte (ALU responses only).
- RX_D_VALID outside IDLE/WR_*/RD_ADDR/ALU_A/ALU_B/ALU_FUN (i.e. RD_WAIT, ALU_WAIT, TX_*) is dropped; no queuing.
- WrEn and RdEn are never both 1. ALU_EN never coincides with WrEn.
- Reset asserted mid-frame or mid-transmit: outputs clear immediately (async) and the partial frame is discarded.
- RdData_Valid/ALU_OUT_VALID outside their wait states are ignored.

Test Plan:
- Write: RX bytes 0xAA, 0x05, 0x3C -> one WrEn pulse, Address=5, WrData=0x3C; no TX_D_VALID; FSM back in IDLE.
- Read: 0xBB, 0x05, with RdData=0x3C/RdData_Valid one cycle after RdEn -> one RdEn pulse, Address=5, then TX_D_VALID with TX_P_DATA=0x3C.
- ALU with operands: 0xCC, 0x0A, 0x03, 0x00 -> WrEn to addr0=0x0A and addr1=0x03, ALU_EN with ALU_FUN=0, CLK_GATE_EN high until ALU_OUT_VALID. ALU_OUT=0x000D -> TX 0x0D then 0x00, second pulse only after a TX_BUSY 1->0 cycle.
- Backpressure: TX_BUSY held 1 for 20 cycles on a read response -> TX_D_VALID withheld, then exactly one pulse after TX_BUSY drops.
- Unknown/dropped: 0x55 in IDLE -> no strobes. A byte arriving during ALU_WAIT -> ignored; response unchanged.
- Reset mid-frame: 0xAA, 0x05, RST low, release, then 0x3C -> no WrEn; all outputs 0 during reset.

Source files
------------

// File: rtl/sys_ctrl.sv
// Command controller between the UART byte stream and the register file / ALU.
// Parses command frames, issues RF and ALU strobes, and streams results back to the transmitter.
//
// state     | meaning
// S_IDLE    | waiting for a command byte
// S_WR_ADDR | RF write: waiting for the address byte
// S_WR_DATA | RF write: waiting for the data byte
// S_RD_ADDR | RF read: waiting for the address byte
// S_RD_WAIT | RF read issued, waiting for RdData_Valid
// S_ALU_A   | ALU with operands: waiting for operand A
// S_ALU_B   | ALU with operands: waiting for operand B
// S_ALU_FUN | waiting for the ALU function byte
// S_ALU_WAIT| ALU running, waiting for ALU_OUT_VALID
// S_TX_B0   | sending the low (or only) response byte
// S_TX_B1   | sending the high response byte

module sys_ctrl #(
    parameter int WIDTH         = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         RX_P_DATA,
    input  logic                     RX_D_VALID,
    output logic                     WrEn,
    output logic                     RdEn,
    output logic [ADDR_WIDTH-1:0]    Address,
    output logic [WIDTH-1:0]         WrData,
    input  logic [WIDTH-1:0]         RdData,
    input  logic                     RdData_Valid,
    output logic                     ALU_EN,
    output logic [3:0]               ALU_FUN,
    output logic                     CLK_GATE_EN,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VALID,
    output logic [WIDTH-1:0]         TX_P_DATA,
    output logic                     TX_D_VALID,
    input  logic                     TX_BUSY
);

    localparam logic [WIDTH-1:0] CMD_RF_WR   = WIDTH'(8'hAA);
    localparam logic [WIDTH-1:0] CMD_RF_RD   = WIDTH'(8'hBB);
    localparam logic [WIDTH-1:0] CMD_ALU_OP  = WIDTH'(8'hCC);
    localparam logic [WIDTH-1:0] CMD_ALU_NOP = WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_ALU_A,
        S_ALU_B,
        S_ALU_FUN,
        S_ALU_WAIT,
        S_TX_B0,
        S_TX_B1
    } state_t;

    // Per-byte transmit handshake: send, then see busy rise, then see busy fall.
    typedef enum logic [1:0] {
        TXP_SEND,
        TXP_BUSY_HI,
        TXP_BUSY_LO
    } tx_phase_t;

    state_t                   r_state;
    tx_phase_t                r_tx_phase;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [ALU_OUT_WIDTH-1:0] r_resp;
    logic                     r_two_byte;

    logic                     r_wr_en;
    logic                     r_rd_en;
    logic [ADDR_WIDTH-1:0]    r_address;
    logic [WIDTH-1:0]         r_wr_data;
    logic                     r_alu_en;
    logic [3:0]               r_alu_fun;
    logic                     r_gate_en;
    logic [WIDTH-1:0]         r_tx_data;
    logic                     r_tx_valid;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_tx_phase <= TXP_SEND;
            r_addr     <= '0;
            r_resp     <= '0;
            r_two_byte <= 1'b0;
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_address  <= '0;
            r_wr_data  <= '0;
            r_alu_en   <= 1'b0;
            r_alu_fun  <= '0;
            r_gate_en  <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_alu_en   <= 1'b0;
            r_tx_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (RX_D_VALID) begin
                        case (RX_P_DATA)
                            CMD_RF_WR:   r_state <= S_WR_ADDR;
                            CMD_RF_RD:   r_state <= S_RD_ADDR;
                            CMD_ALU_OP:  r_state <= S_ALU_A;
                            CMD_ALU_NOP: r_state <= S_ALU_FUN;
                            default:     r_state <= S_IDLE;
                        endcase
                    end
                end

                S_WR_ADDR: begin
                    if (RX_D_VALID) begin
                        r_addr  <= RX_P_DATA[ADDR_WIDTH-1:0];
                        r_state <= S_WR_DATA;
                    end
                end

                S_WR_DATA: begin
                    if (RX_D_VALID) begin
                        r_wr_en   <= 1'b1;
                        r_address <= r_addr;
                        r_wr_data <= RX_P_DATA;
                        r_state   <= S_IDLE;
                    end
                end

                S_RD_ADDR: begin
                    if (RX_D_VALID) begin
                        r_rd_en   <= 1'b1;
                        r_address <= RX_P_DATA[ADDR_WIDTH-1:0];
                        r_state   <= S_RD_WAIT;
                    end
                end

                S_RD_WAIT: begin
                    if (RdData_Valid) begin
                        r_resp     <= ALU_OUT_WIDTH'(RdData);
                        r_two_byte <= 1'b0;
                        r_tx_phase <= TXP_SEND;
                        r_state    <= S_TX_B0;
                    end
                end

                // Operands land in RF locations 0 and 1, where the ALU reads them.
                S_ALU_A: begin
                    if (RX_D_VALID) begin
                        r_wr_en   <= 1'b1;
                        r_address <= '0;
                        r_wr_data <= RX_P_DATA;
                        r_state   <= S_ALU_B;
                    end
                end

                S_ALU_B: begin
                    if (RX_D_VALID) begin
                        r_wr_en   <= 1'b1;
                        r_address <= ADDR_WIDTH'(1);
                        r_wr_data <= RX_P_DATA;
                        r_state   <= S_ALU_FUN;
                    end
                end

                S_ALU_FUN: begin
                    if (RX_D_VALID) begin
                        r_alu_en  <= 1'b1;
                        r_alu_fun <= RX_P_DATA[3:0];
                        r_gate_en <= 1'b1;
                        r_state   <= S_ALU_WAIT;
                    end
                end

                S_ALU_WAIT: begin
                    if (ALU_OUT_VALID) begin
                        r_resp     <= ALU_OUT;
                        r_two_byte <= 1'b1;
                        r_gate_en  <= 1'b0;
                        r_tx_phase <= TXP_SEND;
                        r_state    <= S_TX_B0;
                    end
                end

                S_TX_B0, S_TX_B1: begin
                    case (r_tx_phase)
                        TXP_SEND: begin
                            if (!TX_BUSY) begin
                                r_tx_valid <= 1'b1;
                                r_tx_data  <= (r_state == S_TX_B0) ? r_resp[WIDTH-1:0]
                                                                   : r_resp[ALU_OUT_WIDTH-1:WIDTH];
                                r_tx_phase <= TXP_BUSY_HI;
                            end
                        end
                        TXP_BUSY_HI: begin
                            if (TX_BUSY) begin
                                r_tx_phase <= TXP_BUSY_LO;
                            end
                        end
                        TXP_BUSY_LO: begin
                            if (!TX_BUSY) begin
                                r_tx_phase <= TXP_SEND;
                                if (r_state == S_TX_B0 && r_two_byte) begin
                                    r_state <= S_TX_B1;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end
                        end
                        default: r_tx_phase <= TXP_SEND;
                    endcase
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign WrEn        = r_wr_en;
    assign RdEn        = r_rd_en;
    assign Address     = r_address;
    assign WrData      = r_wr_data;
    assign ALU_EN      = r_alu_en;
    assign ALU_FUN     = r_alu_fun;
    assign CLK_GATE_EN = r_gate_en;
    assign TX_P_DATA   = r_tx_data;
    assign TX_D_VALID  = r_tx_valid;

    // Strobes that must never overlap on the shared RF/ALU side.
    assert property (@(posedge CLK) disable iff (!RST) !(r_wr_en && r_rd_en));
    assert property (@(posedge CLK) disable iff (!RST) !(r_wr_en && r_alu_en));

endmodule
